// File: rtl/vppm_pkg.sv
// ============================================================================
// vppm_pkg: shared VPPM types, constants and pulse-width helper (tx and rx).
// Rev 1.0
// ============================================================================
`default_nettype none

package vppm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } vppm_state_t;

  localparam int DUTY_WIDTH         = 8;
  localparam int DEFAULT_CLOCK_FREQ = 200000000;

  // H = max(1, min(P-1, (P*duty)>>8)); the 24-bit product always fits for P <= 65535.
  function automatic logic [15:0] calc_pulse_width(
    input logic [15:0]           period,
    input logic [DUTY_WIDTH-1:0] duty
  );
    logic [23:0] prod;
    logic [15:0] scaled;
    prod   = 24'(period) * 24'(duty);
    scaled = 16'(prod >> 8);
    if (scaled > period - 16'd1) scaled = period - 16'd1;
    if (scaled == 16'd0) scaled = 16'd1;
    return scaled;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vppm_if.sv
// ============================================================================
// vppm_if: valid/ready word handshake plus dimming duty for the VPPM transmitter.
// Rev 1.0
// ============================================================================
`default_nettype none

interface vppm_if import vppm_pkg::*; #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DUTY_WIDTH-1:0] duty;

  modport master (
    output tx_data,
    output tx_valid,
    output duty,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  duty,
    output tx_ready
  );

endinterface

`default_nettype wire

// File: rtl/vppm_symbol_gen.sv
// ============================================================================
// vppm_symbol_gen: symbol counter and registered waveform for one VPPM symbol.
// Rev 1.0
// ============================================================================
`default_nettype none

module vppm_symbol_gen #(
  parameter int PERIOD_CYCLES = 2000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        run,          // a symbol is in progress this cycle
  input  wire logic        emit,         // a symbol will be in progress next cycle
  input  wire logic        bit_val,      // symbol value for next cycle
  input  wire logic [15:0] pulse_width,  // H for next cycle
  output logic             vppm_out,
  output logic             last
);

  localparam logic [15:0] P_CYC  = 16'(PERIOD_CYCLES);
  localparam logic [15:0] P_LAST = 16'(PERIOD_CYCLES - 1);

  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic        level_next;

  assign last = run && (cnt == P_LAST);

  // Counter sits at 0 while idle so the first frame symbol starts at cycle 0.
  always_comb begin
    cnt_next = 16'd0;
    if (run && (cnt != P_LAST)) cnt_next = cnt + 16'd1;
  end

  // Output is registered, so the level is computed for the cycle about to start.
  always_comb begin
    level_next = 1'b0;
    if (emit) begin
      if (bit_val) level_next = (cnt_next >= (P_CYC - pulse_width));
      else         level_next = (cnt_next < pulse_width);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 16'd0;
      vppm_out <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      vppm_out <= level_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vppm_transmitter.sv
// ============================================================================
// vppm_transmitter: preamble + MSB-first VPPM serialiser with streaming input.
// Rev 1.0
// ============================================================================
`default_nettype none

module vppm_transmitter import vppm_pkg::*; #(
  parameter int CLOCK_FREQ    = DEFAULT_CLOCK_FREQ,
  parameter int PERIOD_CYCLES = 2000,
  parameter int PREAMBLE_BITS = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  wire logic clk,
  input  wire logic rst,
  vppm_if.slave     tx,
  output logic      vppm_out,
  output logic      busy
);

  localparam logic [15:0] P_CYC    = 16'(PERIOD_CYCLES);
  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_BITS - 1);
  localparam logic [3:0]  DAT_LAST = 4'(DATA_WIDTH - 1);

  if ((PERIOD_CYCLES < 4) || (PERIOD_CYCLES > 65535) || (PREAMBLE_BITS < 1) ||
      (PREAMBLE_BITS > 15) || (DATA_WIDTH < 2) || (DATA_WIDTH > 16) || (CLOCK_FREQ < 1))
  begin : g_param_check
    $error("vppm_transmitter: parameter out of legal range");
  end

  vppm_state_t           state, state_next;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic [3:0]            bit_cnt, bit_cnt_next;
  logic [15:0]           pulse_width, pulse_width_next;
  logic                  ready;
  logic                  load;
  logic                  sym_last;

  always_comb begin
    state_next       = state;
    shreg_next       = shreg;
    bit_cnt_next     = bit_cnt;
    pulse_width_next = pulse_width;
    ready            = 1'b0;
    load             = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (tx.tx_valid) begin
          load         = 1'b1;
          bit_cnt_next = 4'd0;
          state_next   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (sym_last) begin
          if (bit_cnt == PRE_LAST) begin
            bit_cnt_next = 4'd0;
            state_next   = DATA;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (sym_last) begin
          if (bit_cnt == DAT_LAST) begin
            // Back-to-back words skip the preamble; the receiver is already locked.
            ready = 1'b1;
            if (tx.tx_valid) begin
              load         = 1'b1;
              bit_cnt_next = 4'd0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            shreg_next   = {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      shreg_next       = tx.tx_data;
      pulse_width_next = calc_pulse_width(P_CYC, tx.duty);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= 4'd0;
      pulse_width <= 16'd0;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      bit_cnt     <= bit_cnt_next;
      pulse_width <= pulse_width_next;
    end
  end

  assign tx.tx_ready = ready;
  assign busy        = (state != IDLE);

  vppm_symbol_gen #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_symbol_gen (
    .clk         (clk),
    .rst         (rst),
    .run         (state != IDLE),
    .emit        (state_next != IDLE),
    .bit_val     ((state_next == DATA) && shreg_next[DATA_WIDTH-1]),
    .pulse_width (pulse_width_next),
    .vppm_out    (vppm_out),
    .last        (sym_last)
  );

endmodule

`default_nettype wire
